// File: rtl/magic_commit_buffer_if.sv
// magic_commit_buffer_if: dispatch, completion-bus and register-file write signals of the commit buffer.
interface magic_commit_buffer_if #(
    parameter int TAG_W = 3
);
    logic             flush;
    logic             dispatch_valid;
    logic             dispatch_ready;
    logic [4:0]       dispatch_rd_addr;
    logic [TAG_W-1:0] dispatch_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             rd_we;
    logic [4:0]       rd_addr;
    logic [31:0]      rd_wdata;
    logic [TAG_W:0]   count;

    modport master (
        output flush, dispatch_valid, dispatch_rd_addr, cdb_valid, cdb_tag, cdb_data,
        input  dispatch_ready, dispatch_tag, rd_we, rd_addr, rd_wdata, count
    );
    modport slave (
        input  flush, dispatch_valid, dispatch_rd_addr, cdb_valid, cdb_tag, cdb_data,
        output dispatch_ready, dispatch_tag, rd_we, rd_addr, rd_wdata, count
    );
endinterface

// File: rtl/magic_commit_buffer.sv
// magic_commit_buffer: in-order commit buffer feeding the magic register file write port.
module magic_commit_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    magic_commit_buffer_if.slave bus
);
    typedef logic [TAG_W:0] ptr_t;

    ptr_t             head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [TAG_W-1:0] head_idx, tail_idx;
    logic             full, dispatch_fire, cdb_fire, commit;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

    // Reset also gates commit so the write port is quiet while rst is high.
    assign dispatch_fire = bus.dispatch_valid && !full && !bus.flush;
    assign cdb_fire      = bus.cdb_valid && valid_q[bus.cdb_tag] && !done_q[bus.cdb_tag] && !bus.flush;
    assign commit        = valid_q[head_idx] && done_q[head_idx] && !bus.flush && !rst;

    assign bus.dispatch_ready = !full;
    assign bus.dispatch_tag   = tail_idx;
    assign bus.count          = tail_q - head_q;
    assign bus.rd_we          = commit && (rd_q[head_idx] != 5'd0);
    assign bus.rd_addr        = commit ? rd_q[head_idx] : 5'd0;
    assign bus.rd_wdata       = commit ? data_q[head_idx] : 32'd0;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (dispatch_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + ptr_t'(1);
        end
        if (cdb_fire)
            done_d[bus.cdb_tag] = 1'b1;
        if (commit) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + ptr_t'(1);
        end
        if (bus.flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dispatch_fire)
            rd_q[tail_idx] <= bus.dispatch_rd_addr;
        if (cdb_fire)
            data_q[bus.cdb_tag] <= bus.cdb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (bus.count <= (TAG_W+1)'(DEPTH));
            assert (!(dispatch_fire && full));
            assert (!bus.rd_we || bus.rd_addr != 5'd0);
        end
    end
endmodule

// File: tb/tb_magic_commit_buffer.sv
// tb_magic_commit_buffer: directed and random stimulus checked against a queue-based program-order model.
module tb_magic_commit_buffer;
    localparam int DEPTH = 8;
    localparam int TW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    magic_commit_buffer_if #(.TAG_W(TW)) bus();
    magic_commit_buffer #(.DEPTH(DEPTH), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        bit          done;
        logic [31:0] data;
        int          tag;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each step: drive inputs after negedge, check outputs against the model, then advance the model.
    task automatic step(input bit r, input bit fl, input bit dv, input logic [4:0] rd,
                        input bit cv, input int ct, input logic [31:0] cd);
        bit          ready, cm;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        ent_t        e;
        @(negedge clk);
        rst                  = r;
        bus.flush            = fl;
        bus.dispatch_valid   = dv;
        bus.dispatch_rd_addr = rd;
        bus.cdb_valid        = cv;
        bus.cdb_tag          = TW'(ct);
        bus.cdb_data         = cd;
        #1;
        ready  = q.size() < DEPTH;
        cm     = 1'b0;
        e_addr = 5'd0;
        e_data = 32'd0;
        if (!r && !fl && q.size() > 0) begin
            if (q[0].done) begin
                cm     = 1'b1;
                e_addr = q[0].rd;
                e_data = q[0].data;
            end
        end
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("dispatch_ready", 32'(bus.dispatch_ready), 32'(ready));
        chk("dispatch_tag", 32'(bus.dispatch_tag), 32'(m_tail));
        chk("rd_we", 32'(bus.rd_we), 32'(cm && e_addr != 5'd0));
        chk("rd_addr", 32'(bus.rd_addr), 32'(e_addr));
        chk("rd_wdata", bus.rd_wdata, e_data);
        if (r || fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (cv)
                foreach (q[i])
                    if (q[i].tag == ct && !q[i].done) begin
                        q[i].done = 1'b1;
                        q[i].data = cd;
                    end
            if (cm)
                void'(q.pop_front());
            if (dv && ready) begin
                e.rd   = rd;
                e.done = 1'b0;
                e.data = 32'd0;
                e.tag  = m_tail;
                q.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 5'd0, 0, 0, 32'd0);
    endtask

    task automatic disp(input logic [4:0] rd);
        step(0, 0, 1, rd, 0, 0, 32'd0);
    endtask

    task automatic comp(input int ct, input logic [31:0] cd);
        step(0, 0, 0, 5'd0, 1, ct, cd);
    endtask

    task automatic flush();
        step(0, 1, 0, 5'd0, 0, 0, 32'd0);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.flush            = 1'b0;
        bus.dispatch_valid   = 1'b0;
        bus.dispatch_rd_addr = 5'd0;
        bus.cdb_valid        = 1'b0;
        bus.cdb_tag          = '0;
        bus.cdb_data         = 32'd0;
        repeat (2) @(posedge clk);
        idle();
        // Single entry round trip.
        disp(5'd5);
        comp(0, 32'hDEADBEEF);
        idle();
        idle();
        // Out-of-order completion, in-order commit.
        disp(5'd1);
        disp(5'd2);
        disp(5'd3);
        comp(2, 32'h30);
        idle();
        comp(0, 32'h10);
        comp(1, 32'h20);
        repeat (3) idle();
        flush();
        // Fill, reject overflow, drain head, wrap.
        for (int i = 0; i < DEPTH; i++) disp(5'(i + 10));
        disp(5'd31);
        comp(0, 32'hA0);
        idle();
        disp(5'd20);
        flush();
        // rd=0 retires silently.
        disp(5'd0);
        disp(5'd7);
        comp(0, 32'h111);
        comp(1, 32'h777);
        repeat (2) idle();
        flush();
        // Unallocated, duplicate, and dispatch-with-commit cases.
        comp(5, 32'hBAD);
        disp(5'd9);
        step(0, 0, 1, 5'd4, 1, 0, 32'h99);
        comp(0, 32'hBAD0);
        step(0, 0, 1, 5'd6, 0, 0, 32'd0);
        comp(1, 32'h44);
        comp(2, 32'h66);
        repeat (3) idle();
        flush();
        // Flush while head is committable.
        for (int i = 1; i <= 4; i++) disp(5'(i));
        comp(1, 32'h22);
        comp(0, 32'h11);
        flush();
        comp(2, 32'h33);
        idle();
        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            int ct;
            ct = $urandom_range(0, DEPTH - 1);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                ct = q[$urandom_range(0, q.size() - 1)].tag;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom_range(0, 2) != 0, ct, $urandom);
        end
        step(1, 0, 1, 5'd3, 0, 0, 32'd0);
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/magic_commit_buffer.md
Name: magic_commit_buffer

Overview:
- In-order commit buffer that sits directly upstream of the magic register file and drives its single write port (rd_we, rd_addr, rd_wdata).
- Dispatch allocates a tagged entry per destination-writing instruction. Functional units complete entries out of order over a single completion bus.
- The buffer retires completed entries strictly in allocation order, at most one per cycle, so architectural register writes are always in program order.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- TAG_W, $clog2(DEPTH), width of entry tag.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries.
- dispatch_valid  in  1  allocation request.
- dispatch_ready  out  1  buffer can accept an allocation.
- dispatch_rd_addr  in  5  destination architectural register.
- dispatch_tag  out  TAG_W  tag assigned to the allocation (tail index).
- cdb_valid  in  1  completion broadcast valid.
- cdb_tag  in  TAG_W  tag of the completing entry.
- cdb_data  in  32  result value.
- rd_we  out  1  register file write enable.
- rd_addr  out  5  register file write address.
- rd_wdata  out  32  register file write data.
- count  out  TAG_W+1  number of occupied entries.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - head and tail pointers are 0; each pointer has TAG_W index bits plus one wrap bit.
  - All entry valid and done bits are 0.
  - count=0 and dispatch_ready=1.
  - rd_we=0, rd_addr=0, rd_wdata=0.
  - Entry data arrays need no reset.
- Empty and full:
  - empty when head==tail.
  - full when the indices are equal and the wrap bits differ.
- dispatch_ready = !full. It does not account for a same-cycle commit (conservative).
- dispatch_tag = tail index, combinational.
- Dispatch fires on dispatch_valid && dispatch_ready && !flush:
  - entry[tail] is written with valid=1, done=0, rd=dispatch_rd_addr.
  - tail increments and wraps naturally through the wrap bit.
- Completion fires on cdb_valid && entry[cdb_tag].valid && !entry[cdb_tag].done && !flush:
  - entry data is set to cdb_data and done=1.
  - A completion to an unallocated entry is ignored.
  - A completion to an already-done entry is ignored; the first completion wins.
  - A completion to the entry being dispatched in the same cycle is ignored, because that entry is not yet valid.
- Commit condition: commit = entry[head].valid && entry[head].done && !flush. This is combinational from state.
- Commit outputs (combinational):
  - rd_we = commit && (entry[head].rd != 0).
  - rd_addr = entry[head].rd and rd_wdata = entry[head].data when commit is true; both are 0 otherwise.
  - An entry with rd==0 retires silently (rd_we=0) but still advances head.
- On commit at the clock edge: entry[head].valid=0, done=0, and head increments. At most one commit per cycle.
- Commit latency: a completion in cycle N is committed in cycle N+1 at the earliest, if that entry is head. The register file captures the write at the end of N+1.
- Simultaneous events:
  - Dispatch, completion and commit in the same cycle all take effect.
  - count' = count + dispatch_fire − commit.
  - When empty, the dispatched entry cannot commit in the same cycle.
- Flush (priority over dispatch, completion and commit):
  - suppresses rd_we in that cycle.
  - clears all valid and done bits; sets head=tail=0; count=0 next cycle.
- rst asserted mid-operation has the same effect as flush plus output zeroing, and beats flush.
- Invariants (assertions):
  - count <= DEPTH.
  - No dispatch fire when full.
  - rd_we implies rd_addr != 0.

Test Plan:
- Reset, then dispatch rd=5 (tag 0). Complete tag 0 with 0xDEADBEEF → the next cycle shows rd_we=1, rd_addr=5, rd_wdata=0xDEADBEEF for exactly one cycle; count returns to 0.
- Dispatch rd=1, 2, 3 (tags 0–2). Complete in order 2, 0, 1 with 0x30, 0x10, 0x20 → commits follow register order 1, 2, 3 with matching data on consecutive cycles. No commit occurs before tag 0 completes.
- Fill DEPTH=8 entries → dispatch_ready=0 and count=8; a further dispatch_valid is not accepted. Complete head → ready returns after commit. Subsequent tags wrap to 0.
- Dispatch rd=0, then rd=7. Complete both → the rd=0 entry retires with rd_we=0, followed by rd_we=1 with rd_addr=7.
- Same-cycle cases:
  - A completion to an unallocated tag has no effect.
  - A duplicate completion to a done entry keeps the first data.
  - Dispatch and commit in one cycle keep count unchanged.
- With 4 entries, 2 of them done: assert flush in the cycle head is committable → rd_we=0. Next cycle count=0, dispatch_tag=0, and a later completion to an old tag is ignored.
